regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register file constants and helpers, used by the register file and its write arbiter.
package regfile_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_WIDTH  = 3;
    localparam int NUM_REGS   = 1 << NUM_WIDTH;

    // Next index in a circular search over n requesters.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the requesters and the register file write arbiter.
// Requester i occupies slice i of reqNum/reqData.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int NUM_WIDTH  = regfile_pkg::NUM_WIDTH
);

    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ*NUM_WIDTH-1:0]  reqNum;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            reqAck;
    logic                          rdWriteEnable;
    logic [NUM_WIDTH-1:0]          rdNum;
    logic [DATA_WIDTH-1:0]         rdData;
    logic [2**NUM_WIDTH-1:0]       busyMask;

    // Requester side.
    modport master (
        output reqValid, reqNum, reqData,
        input  reqAck, rdWriteEnable, rdNum, rdData, busyMask
    );

    // Arbiter side.
    modport slave (
        input  reqValid, reqNum, reqData,
        output reqAck, rdWriteEnable, rdNum, rdData, busyMask
    );

endinterface

// File: rtl/rr_arbiter.sv
// Request vector in, one-hot grant out.
// Macro REGFILE_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (lowest index wins).
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    input  logic               clock,
    input  logic               reset,
`endif
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant
);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] pointer;
    logic [PTR_W-1:0] grantIdx;
    logic             found;

    // Circular search for the first request at or after the pointer.
    always_comb begin
        int sum;
        logic [PTR_W-1:0] idx;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        sum      = 0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(pointer) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = PTR_W'(sum);
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                grantIdx   = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer moves to the requester after the one just granted.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (reset)
            pointer <= '0;
        else if (found)
            pointer <= PTR_W'(wrapInc(int'(grantIdx), NUM_REQ));
    end
`else
    // Isolate the lowest set request bit.
    assign grant = request & (~request + NUM_REQ'(1));
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write arbiter: picks one requester per cycle and drives a registered write strobe.
// Macro REGFILE_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int NUM_WIDTH  = regfile_pkg::NUM_WIDTH
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave wrBus
);

    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      ackQ;
    logic                    weQ;
    logic [NUM_WIDTH-1:0]    numQ;
    logic [NUM_WIDTH-1:0]    selNum;
    logic [DATA_WIDTH-1:0]   dataQ;
    logic [DATA_WIDTH-1:0]   selData;
    logic [2**NUM_WIDTH-1:0] busy;

    // A requester acked this cycle still holds its request; keep it out of this edge's arbitration.
    assign eligible = wrBus.reqValid & ~ackQ;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) arbiter (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        .clock  (clock),
        .reset  (reset),
`endif
        .request(eligible),
        .grant  (grant)
    );

    // Route the granted requester's address and data (grant is one-hot).
    always_comb begin
        selNum  = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selNum  = wrBus.reqNum[i*NUM_WIDTH +: NUM_WIDTH];
                selData = wrBus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered grant and write port; address/data hold their last value when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ackQ  <= '0;
            weQ   <= 1'b0;
            numQ  <= '0;
            dataQ <= '0;
        end else begin
            ackQ <= grant;
            weQ  <= |grant;
            if (|grant) begin
                numQ  <= selNum;
                dataQ <= selData;
            end
        end
    end

    // Registers with a pending request or a write in progress.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wrBus.reqValid[i])
                busy[wrBus.reqNum[i*NUM_WIDTH +: NUM_WIDTH]] = 1'b1;
        end
        if (weQ)
            busy[numQ] = 1'b1;
    end

    assign wrBus.reqAck        = ackQ;
    assign wrBus.rdWriteEnable = weQ;
    assign wrBus.rdNum         = numQ;
    assign wrBus.rdData        = dataQ;
    assign wrBus.busyMask      = busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; expected grant sequences follow the
// build selected by REGFILE_ARB_ROUND_ROBIN_EN.
module tb_regfile_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int NW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    regfile_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_WIDTH(NW)) bus ();

    regfile_write_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .NUM_WIDTH (NW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wrBus(bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [NW-1:0] num;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expQ[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [NW-1:0] numTab[NR];
    logic [DW-1:0] dataTab[NR];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic loadReq(input int i, input logic [NW-1:0] n, input logic [DW-1:0] d);
        numTab[i]  = n;
        dataTab[i] = d;
        bus.reqNum[i*NW +: NW]  = n;
        bus.reqData[i*DW +: DW] = d;
    endtask

    task automatic expectGrant(input int i);
        exp_t e;
        e.ack  = NR'(1) << i;
        e.num  = numTab[i];
        e.data = dataTab[i];
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every strobe must match the head of the scoreboard; idle cycles carry no ack.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.rdWriteEnable === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious strobe: ack=%0h num=%0h data=%0h expected none (t=%0t)",
                         bus.reqAck, bus.rdNum, bus.rdData, $time);
            end else begin
                e = expQ.pop_front();
                check("strobe ack", 32'(bus.reqAck), 32'(e.ack));
                check("strobe rdNum", 32'(bus.rdNum), 32'(e.num));
                check("strobe rdData", 32'(bus.rdData), 32'(e.data));
            end
        end else begin
            check("idle we", 32'(bus.rdWriteEnable), 32'd0);
            check("idle ack", 32'(bus.reqAck), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        int seqAll[5] = '{0, 1, 2, 3, 0};
`else
        int seqAll[5] = '{0, 1, 0, 1, 0};
`endif
        int seqPair[4] = '{1, 2, 1, 2};

        bus.reqValid = '0;
        bus.reqNum   = '0;
        bus.reqData  = '0;
        tick(3);

        // Reset state
        check("reset we", 32'(bus.rdWriteEnable), 32'd0);
        check("reset ack", 32'(bus.reqAck), 32'd0);
        check("reset rdNum", 32'(bus.rdNum), 32'd0);
        check("reset rdData", 32'(bus.rdData), 32'd0);
        check("reset busyMask", 32'(bus.busyMask), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single request: one strobe to reg 5 with A5, then address/data hold
        loadReq(0, 3'd5, 8'hA5);
        bus.reqValid = 4'b0001;
        expectGrant(0);
        #1;
        check("single busy pending", 32'(bus.busyMask), 32'h20);
        tick(1);
        bus.reqValid = 4'b0000;
        #1;
        check("single busy writing", 32'(bus.busyMask), 32'h20);
        tick(1);
        check("single we drops", 32'(bus.rdWriteEnable), 32'd0);
        check("single rdNum holds", 32'(bus.rdNum), 32'd5);
        check("single rdData holds", 32'(bus.rdData), 32'hA5);
        check("single busy clear", 32'(bus.busyMask), 32'd0);
        tick(1);

        // All four requesting continuously: one write per cycle
        loadReq(0, 3'd1, 8'h10);
        loadReq(1, 3'd2, 8'h21);
        loadReq(2, 3'd4, 8'h42);
        loadReq(3, 3'd7, 8'h73);
        for (int k = 0; k < 5; k++) expectGrant(seqAll[k]);
        bus.reqValid = 4'b1111;
        tick(5);
        bus.reqValid = 4'b0000;
        tick(2);

        // Requesters 1 and 2 held: ack mask alternates them
        for (int k = 0; k < 4; k++) expectGrant(seqPair[k]);
        bus.reqValid = 4'b0110;
        tick(4);
        bus.reqValid = 4'b0000;
        tick(2);

        // Two writes to reg 3; busy until the second strobe ends, later data final
        loadReq(0, 3'd3, 8'h11);
        loadReq(2, 3'd3, 8'h22);
        expectGrant(0);
        expectGrant(2);
        bus.reqValid = 4'b0101;
        tick(1);
        bus.reqValid = 4'b0100;
        #1;
        check("samereg busy after first", 32'(bus.busyMask[3]), 32'd1);
        tick(1);
        bus.reqValid = 4'b0000;
        #1;
        check("samereg busy during second", 32'(bus.busyMask[3]), 32'd1);
        tick(1);
        check("samereg busy clear", 32'(bus.busyMask), 32'd0);
        check("samereg final data", 32'(bus.rdData), 32'h22);
        tick(1);

        // Withdrawal: requester 1 pulses for one cycle while 0 wins; never acked
        loadReq(0, 3'd6, 8'h5C);
        loadReq(1, 3'd7, 8'h77);
        expectGrant(0);
        bus.reqValid = 4'b0011;
        tick(1);
        bus.reqValid = 4'b0000;
        tick(3);

        // Reset on the edge after a grant; arbitration restarts from requester 0
        loadReq(0, 3'd2, 8'hC3);
        loadReq(1, 3'd5, 8'h3C);
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        expectGrant(1);
`else
        expectGrant(0);
`endif
        bus.reqValid = 4'b0011;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("midreset we", 32'(bus.rdWriteEnable), 32'd0);
        check("midreset ack", 32'(bus.reqAck), 32'd0);
        check("midreset rdNum", 32'(bus.rdNum), 32'd0);
        check("midreset rdData", 32'(bus.rdData), 32'd0);
        check("midreset busyMask", 32'(bus.busyMask), 32'h24);
        reset = 1'b0;
        expectGrant(0);
        tick(1);
        bus.reqValid = 4'b0010;
        expectGrant(1);
        tick(1);
        bus.reqValid = 4'b0000;
        tick(3);

        check("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
